calc_mport_core: RTL and testbench
==================================

Name: calc_mport_core

Overview:
- Parametrised multi-port calculator core, successor to the fixed 4-port/32-bit calc1 engine.
- NUM_PORTS independent request ports share one registered ALU through a round-robin arbiter.
- Each port uses the two-cycle operand protocol: operand1 arrives with the command, operand2 on the following cycle.
- Adds a per-port busy indication and deterministic arbitration fairness, neither of which calc1 has.

Parameters:
- NUM_PORTS, 4, number of request/response channels (1..8).
- DATA_W, 32, operand and result width (8..64, power of two).
- SHAMT_W, $clog2(DATA_W), derived; operand2 bits used as shift amount.

Ports:
- c_clk  input  1  core clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_cmd_in  input  4*NUM_PORTS  per-port command; port p at [4p+3:4p].
- req_data_in  input  DATA_W*NUM_PORTS  per-port operand bus; port p at [DATA_W*p +: DATA_W].
- req_busy  output  NUM_PORTS  bit p high while port p is not IDLE.
- out_resp  output  2*NUM_PORTS  per-port response code: 0 none, 1 success, 2 error, 3 reserved/never driven.
- out_data  output  DATA_W*NUM_PORTS  per-port result; 0 whenever out_resp for that port is not 1.

Behaviour:
- Reset (synchronous, active-high):
  - All ports go to IDLE.
  - req_busy, out_resp and out_data are all 0.
  - Round-robin pointer is set so port 0 has highest priority.
  - Reset asserted mid-operation discards all pending operations with no response.
- Commands:
  - 0 no-op.
  - 1 add: op1 + op2.
  - 2 subtract: op1 - op2.
  - 5 shift left: op1 << op2[SHAMT_W-1:0].
  - 6 shift right (logical): op1 >> op2[SHAMT_W-1:0].
  - Any other command is invalid.
- Per-port FSM:
  - IDLE: nonzero cmd sampled at edge E0 latches cmd and op1 -> OP2.
  - OP2: req_data_in sampled at edge E1 latches op2 -> PEND. req_cmd_in is ignored during OP2.
  - PEND: waits for grant. When granted at edge Eg, the result and response are registered into out_data/out_resp for that port -> IDLE.
- Response timing:
  - Response is valid for exactly one cycle after Eg; out_resp returns to 0 at Eg+1 unless a new grant occurs.
  - Minimum latency: E0 to response valid after E0+2 edges.
  - A new command may be sampled at Eg+1.
- Busy/ignore rule: commands presented while the port is busy (OP2 or PEND) are ignored entirely, with no response and no error.
- Arbiter:
  - Exactly one PEND port is granted per cycle.
  - Search order starts at (last granted + 1) mod NUM_PORTS.
  - Each port waits at most NUM_PORTS-1 grants.
  - Grant selection is combinational from PEND state; the ALU result is registered.
- Arithmetic:
  - Add: unsigned carry-out -> resp 2, data 0.
  - Subtract: op2 > op1 (unsigned) -> resp 2, data 0.
  - Shifts never error; bits shifted out are lost; operand2 bits above SHAMT_W are ignored.
  - Invalid command still consumes the op2 cycle and a grant, then gives resp 2, data 0.
- Simultaneous events:
  - All ports may issue on the same edge.
  - Responses then appear on consecutive cycles in round-robin order.
  - Other ports' outputs are held at 0 while not responding.

Optional Feature:
- Macro: CALC_ROTATE_EN.
- When defined:
  - cmd 3 = rotate left op1 by op2[SHAMT_W-1:0].
  - cmd 4 = rotate right op1 by op2[SHAMT_W-1:0].
  - Both always give resp 1.
- When undefined: cmd 3 and cmd 4 are invalid (resp 2, data 0).

Test Plan:
- Reset held 3 cycles, then released -> all out_resp=0, out_data=0, req_busy=0; no response for 10 idle cycles.
- Port 0: cmd 1, op1=0x0000_0005 then op2=0x0000_0007 -> two edges later out_resp[1:0]=1, out_data=0x0000_000C for one cycle.
- Add overflow and subtract underflow:
  - Port 1: cmd 1, op1=0xFFFF_FFFF, op2=1 -> resp 2, data 0.
  - Port 1: cmd 2, op1=3, op2=4 -> resp 2, data 0.
- All 4 ports issue cmd 5 (op1=1, op2=p+1) on the same edge -> responses on 4 consecutive cycles, order 0,1,2,3, data 2,4,8,16.
  - Immediately repeat the same issue -> order starts after the last granted port (0,1,2,3 again, since the pointer wrapped).
- Busy and reset handling:
  - Port 2 issues cmd 6; a new cmd 1 is driven during its OP2 cycle -> ignored, exactly one response (shift result).
  - Reset asserted while port 3 is in PEND -> no response, req_busy[3]=0.
- Invalid commands:
  - cmd 3 with op1=0x8000_0001, op2=1 -> resp 1, data 0x0000_0003 if CALC_ROTATE_EN is defined, else resp 2, data 0.
  - cmd 0xF -> resp 2 in both builds.

Source files
------------

// File: rtl/calc_mport_core.sv
// calc_mport_core: NUM_PORTS request ports sharing one registered ALU
// through a round-robin arbiter. Each port sends a command with operand1,
// then operand2 on the following cycle. The port waits in PEND until it is
// granted, and then gets a one-cycle response.
// Optional build macro: CALC_ROTATE_EN enables cmd 3 (rotate left) and
// cmd 4 (rotate right). Without it, those commands are invalid.
module calc_mport_core #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32
) (
   input  logic                          c_clk,
   input  logic                          reset,
   input  logic [4*NUM_PORTS-1:0]        req_cmd_in,
   input  logic [DATA_W*NUM_PORTS-1:0]   req_data_in,
   output logic [NUM_PORTS-1:0]          req_busy,
   output logic [2*NUM_PORTS-1:0]        out_resp,
   output logic [DATA_W*NUM_PORTS-1:0]   out_data
);

   localparam int SHAMT_W = $clog2(DATA_W);
   localparam int PW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   localparam logic [1:0] RESP_OK  = 2'd1;
   localparam logic [1:0] RESP_ERR = 2'd2;

   typedef enum logic [1:0] {IDLE, OP2, PEND} state_t;

   state_t              state_q [NUM_PORTS];
   state_t              state_d [NUM_PORTS];
   logic [3:0]          cmd_q   [NUM_PORTS];
   logic [DATA_W-1:0]   op1_q   [NUM_PORTS];
   logic [DATA_W-1:0]   op2_q   [NUM_PORTS];

   logic [PW-1:0]        rr_ptr;
   logic [PW-1:0]        gnt_idx;
   logic [PW-1:0]        arb_idx;
   logic                 gnt_vld;
   logic [NUM_PORTS-1:0] gnt;
   int                   arb_k;

   logic [3:0]          g_cmd;
   logic [DATA_W-1:0]   g_op1;
   logic [DATA_W-1:0]   g_op2;
   logic [SHAMT_W-1:0]  sh;
   logic [DATA_W:0]     sum;
   logic [1:0]          alu_resp;
   logic [DATA_W-1:0]   alu_data;
`ifdef CALC_ROTATE_EN
   logic [SHAMT_W:0]    rsh;
`endif

   // Per-port state registers. A reset drops any in-flight operation.
   always_ff @(posedge c_clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (reset) state_q[i] <= IDLE;
         else       state_q[i] <= state_d[i];
      end
   end

   // Operand capture. A port only accepts a command while it is IDLE.
   // operand2 is taken unconditionally in the cycle after the command.
   always_ff @(posedge c_clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (state_q[i] == IDLE && req_cmd_in[4*i +: 4] != 4'd0) begin
            cmd_q[i] <= req_cmd_in[4*i +: 4];
            op1_q[i] <= req_data_in[DATA_W*i +: DATA_W];
         end
         if (state_q[i] == OP2)
            op2_q[i] <= req_data_in[DATA_W*i +: DATA_W];
      end
   end

   // Per-port next-state logic. Commands arriving in OP2 or PEND are ignored.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            IDLE:    if (req_cmd_in[4*i +: 4] != 4'd0) state_d[i] = OP2;
            OP2:     state_d[i] = PEND;
            PEND:    if (gnt[i]) state_d[i] = IDLE;
            default: state_d[i] = IDLE;
         endcase
      end
   end

   // Round-robin search: the first PEND port at or after rr_ptr wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      arb_idx = '0;
      arb_k   = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         arb_k = int'(rr_ptr) + i;
         if (arb_k >= NUM_PORTS) arb_k = arb_k - NUM_PORTS;
         arb_idx = PW'(arb_k);
         if (!gnt_vld && state_q[arb_idx] == PEND) begin
            gnt_vld = 1'b1;
            gnt_idx = arb_idx;
         end
      end
   end

   // One-hot grant vector, decoded from the winning index.
   always_comb begin
      gnt = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         gnt[p] = gnt_vld && (gnt_idx == PW'(p));
   end

   // Shared ALU that operates on the granted port's operands.
   // Any error response forces the data to 0.
   always_comb begin
      g_cmd    = cmd_q[gnt_idx];
      g_op1    = op1_q[gnt_idx];
      g_op2    = op2_q[gnt_idx];
      sh       = g_op2[SHAMT_W-1:0];
      sum      = {1'b0, g_op1} + {1'b0, g_op2};
      alu_resp = RESP_ERR;
      alu_data = '0;
`ifdef CALC_ROTATE_EN
      rsh      = (SHAMT_W+1)'(DATA_W) - {1'b0, sh};
`endif
      case (g_cmd)
         4'd1: if (!sum[DATA_W]) begin
            alu_resp = RESP_OK;
            alu_data = sum[DATA_W-1:0];
         end
         4'd2: if (g_op2 <= g_op1) begin
            alu_resp = RESP_OK;
            alu_data = g_op1 - g_op2;
         end
`ifdef CALC_ROTATE_EN
         4'd3: begin
            alu_resp = RESP_OK;
            alu_data = (g_op1 << sh) | (g_op1 >> rsh);
         end
         4'd4: begin
            alu_resp = RESP_OK;
            alu_data = (g_op1 >> sh) | (g_op1 << rsh);
         end
`endif
         4'd5: begin
            alu_resp = RESP_OK;
            alu_data = g_op1 << sh;
         end
         4'd6: begin
            alu_resp = RESP_OK;
            alu_data = g_op1 >> sh;
         end
         default: begin
            alu_resp = RESP_ERR;
            alu_data = '0;
         end
      endcase
   end

   // Response registers and round-robin pointer.
   // Only the granted port sees a response. Every other port is cleared
   // each cycle, so a response lasts exactly one cycle.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         out_resp <= '0;
         out_data <= '0;
         rr_ptr   <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            out_resp[2*i +: 2]           <= gnt[i] ? alu_resp : 2'd0;
            out_data[DATA_W*i +: DATA_W] <= gnt[i] ? alu_data : '0;
         end
         if (gnt_vld)
            rr_ptr <= (gnt_idx == PW'(NUM_PORTS-1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Busy flag for each port.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++)
         req_busy[i] = (state_q[i] != IDLE);
   end

endmodule

// File: tb/tb_calc_mport_core.sv
// Directed self-checking bench for calc_mport_core (4 ports, 32-bit data).
// The expected values are worked out by hand. CALC_ROTATE_EN selects which
// results are expected for cmd 3 and cmd 4.
module tb_calc_mport_core;

   localparam int NP = 4;
   localparam int DW = 32;

   logic              c_clk = 1'b0;
   logic              reset;
   logic [4*NP-1:0]   req_cmd_in;
   logic [DW*NP-1:0]  req_data_in;
   logic [NP-1:0]     req_busy;
   logic [2*NP-1:0]   out_resp;
   logic [DW*NP-1:0]  out_data;

   int tests = 0;
   int fails = 0;

   calc_mport_core #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .req_busy    (req_busy),
      .out_resp    (out_resp),
      .out_data    (out_data)
   );

   always #5 c_clk = ~c_clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock, then settle just after the edge. Both driving and
   // sampling happen at this point.
   task automatic step();
      @(posedge c_clk);
      #1;
   endtask

   // Run a single operation on one port while the other ports are idle.
   task automatic run_op(input string tag, input int p, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] er, input logic [31:0] ed);
      logic [7:0] m;
      m = 8'h3 << (2*p);
      req_cmd_in[4*p +: 4]    = c;
      req_data_in[DW*p +: DW] = a;
      step();
      chk({tag, "_busy"}, 64'(req_busy[p]), 64'd1);
      req_cmd_in[4*p +: 4]    = 4'd0;
      req_data_in[DW*p +: DW] = b;
      step();
      req_data_in[DW*p +: DW] = '0;
      step();
      chk({tag, "_resp"}, 64'(out_resp[2*p +: 2]), 64'(er));
      chk({tag, "_data"}, 64'(out_data[DW*p +: DW]), 64'(ed));
      chk({tag, "_others"}, 64'(out_resp & ~m), 64'd0);
      chk({tag, "_idle"}, 64'(req_busy[p]), 64'd0);
      step();
      chk({tag, "_clr"}, 64'(out_resp[2*p +: 2]), 64'd0);
   endtask

   // All ports issue cmd 5 (1 << (p+1)) on the same edge. The responses must
   // then appear on consecutive cycles, in the order 0, 1, 2, 3.
   task automatic all_issue(input string tag);
      for (int p = 0; p < NP; p++) begin
         req_cmd_in[4*p +: 4]    = 4'd5;
         req_data_in[DW*p +: DW] = 32'd1;
      end
      step();
      for (int p = 0; p < NP; p++) begin
         req_cmd_in[4*p +: 4]    = 4'd0;
         req_data_in[DW*p +: DW] = 32'(p + 1);
      end
      step();
      req_data_in = '0;
      for (int k = 0; k < NP; k++) begin
         step();
         chk($sformatf("%s_ord%0d", tag, k), 64'(out_resp), 64'(8'h1 << (2*k)));
         chk($sformatf("%s_dat%0d", tag, k), 64'(out_data[DW*k +: DW]), 64'(32'd1 << (k+1)));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nz;
      reset       = 1'b1;
      req_cmd_in  = '0;
      req_data_in = '0;
      repeat (3) step();
      chk("rst_busy", 64'(req_busy), 64'd0);
      chk("rst_resp", 64'(out_resp), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      reset = 1'b0;
      nz = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (out_resp != '0 || out_data != '0 || req_busy != '0) nz++;
      end
      chk("idle_quiet", 64'(nz), 64'd0);

      // Basic arithmetic and the error paths.
      run_op("add",      0, 4'd1, 32'h5,          32'h7, 2'd1, 32'hC);
      run_op("add_ovf",  1, 4'd1, 32'hFFFF_FFFF,  32'h1, 2'd2, 32'h0);
      run_op("sub_unf",  1, 4'd2, 32'h3,          32'h4, 2'd2, 32'h0);
      run_op("sub_ok",   1, 4'd2, 32'hA,          32'h3, 2'd1, 32'h7);
      run_op("shr_max",  3, 4'd6, 32'h8000_0000,  32'd31, 2'd1, 32'h1);

      // Start from a known arbitration pointer, then check the fairness order.
      reset = 1'b1;
      step();
      reset = 1'b0;
      all_issue("rr_a");
      all_issue("rr_b");
      step();
      chk("rr_done", 64'(out_resp), 64'd0);

      // A command sent during OP2 is dropped: only one response may come back.
      req_cmd_in[4*2 +: 4]    = 4'd6;
      req_data_in[DW*2 +: DW] = 32'h80;
      step();
      req_cmd_in[4*2 +: 4]    = 4'd1;
      req_data_in[DW*2 +: DW] = 32'd3;
      step();
      req_data_in[DW*2 +: DW] = '0;
      step();
      req_cmd_in[4*2 +: 4]    = 4'd0;
      chk("busy_resp", 64'(out_resp[5:4]), 64'd1);
      chk("busy_data", 64'(out_data[DW*2 +: DW]), 64'h10);
      nz = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (out_resp != '0 || req_busy != '0) nz++;
      end
      chk("busy_single", 64'(nz), 64'd0);

      // Only the low SHAMT_W bits of operand2 are used as the shift amount.
      run_op("shl_mask", 2, 4'd5, 32'h1, 32'h21, 2'd1, 32'h2);

      // The last grant went to port 2, so port 3 must win over port 0.
      req_cmd_in[4*0 +: 4]    = 4'd1;
      req_data_in[DW*0 +: DW] = 32'd1;
      req_cmd_in[4*3 +: 4]    = 4'd1;
      req_data_in[DW*3 +: DW] = 32'd10;
      step();
      req_cmd_in              = '0;
      req_data_in[DW*0 +: DW] = 32'd1;
      req_data_in[DW*3 +: DW] = 32'd20;
      step();
      req_data_in = '0;
      step();
      chk("ptr_first", 64'(out_resp), 64'h40);
      chk("ptr_first_d", 64'(out_data[DW*3 +: DW]), 64'd30);
      step();
      chk("ptr_second", 64'(out_resp), 64'h01);
      chk("ptr_second_d", 64'(out_data[DW*0 +: DW]), 64'd2);

      // A reset while a port is in PEND discards the operation.
      req_cmd_in[4*3 +: 4]    = 4'd1;
      req_data_in[DW*3 +: DW] = 32'd1;
      step();
      req_cmd_in              = '0;
      req_data_in[DW*3 +: DW] = 32'd2;
      step();
      req_data_in = '0;
      chk("pend_busy", 64'(req_busy[3]), 64'd1);
      reset = 1'b1;
      step();
      chk("rstp_busy", 64'(req_busy[3]), 64'd0);
      chk("rstp_resp", 64'(out_resp), 64'd0);
      reset = 1'b0;
      nz = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (out_resp != '0 || req_busy != '0) nz++;
      end
      chk("rstp_quiet", 64'(nz), 64'd0);

      // Rotate commands and invalid commands.
`ifdef CALC_ROTATE_EN
      run_op("rotl", 0, 4'd3, 32'h8000_0001, 32'h1, 2'd1, 32'h3);
      run_op("rotr", 0, 4'd4, 32'h8000_0001, 32'h1, 2'd1, 32'hC000_0000);
`else
      run_op("rotl", 0, 4'd3, 32'h8000_0001, 32'h1, 2'd2, 32'h0);
      run_op("rotr", 0, 4'd4, 32'h8000_0001, 32'h1, 2'd2, 32'h0);
`endif
      run_op("inv_f", 1, 4'hF, 32'h1234, 32'h1, 2'd2, 32'h0);
      run_op("inv_7", 2, 4'h7, 32'h1,    32'h1, 2'd2, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
